// File: rtl/memory_stage_if.sv
// Data-memory request/response bundle between memory_stage and the data memory.
// Ports: request (valid/ready, addr, we, wstrb, wdata); response (valid, rdata).
interface memory_stage_if #(
    parameter int XLEN = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_addr,
        output mem_we,
        output mem_wstrb,
        output mem_wdata,
        input  mem_rsp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_addr,
        input  mem_we,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_rsp_valid,
        output mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: runs LOAD/STORE transactions on the data memory,
// formats load data into valM and stalls upstream until the access is done.
// Ports: clk, rst (async, active high); in_valid/opcode/func3/valE/valB in;
// valM/done/stall out; mem (memory_stage_if.master) to the data memory;
// misaligned out only when MEMORY_STAGE_MISALIGN_TRAP_EN is defined, which
// also turns misaligned accesses into a trap that skips the memory.
module memory_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] valE,
    input  logic [XLEN-1:0] valB,
    output logic [XLEN-1:0] valM,
    output logic            done,
    output logic            stall,
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    memory_stage_if.master  mem
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              is_load, is_store, is_mem;
    logic              illegal, mis_trap, skip;
    logic              capture, rsp_take;
    logic [1:0]        off;
    logic [XLEN/8-1:0] wstrb_d;
    logic [XLEN-1:0]   wdata_d;

    logic [XLEN-1:0]   addr_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [XLEN/8-1:0] wstrb_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   valm_q;
    logic [XLEN-1:0]   load_fmt;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign off      = valE[1:0];

    // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
    assign illegal = (is_load & ((func3 == 3'b011) | (func3[2:1] == 2'b11)))
                   | (is_store & (func3[2] | (func3 == 3'b011)));

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign mis_trap = is_mem & ~illegal
                    & (((func3[1:0] == 2'b01) & valE[0])
                    | ((func3[1:0] == 2'b10) & (valE[1:0] != 2'b00)));
`else
    assign mis_trap = 1'b0;
`endif

    // Accesses that never reach the memory go straight to DONE.
    assign skip     = illegal | mis_trap;
    assign capture  = (state_q == IDLE) & in_valid & is_mem;
    assign rsp_take = (state_q == WAIT) & mem.mem_rsp_valid;

    // Lane placement is resolved at capture so REQ only replays registers.
    always_comb begin
        wstrb_d = '0;
        wdata_d = '0;
        if (is_store & ~skip) begin
            unique case (func3[1:0])
                2'b00: begin
                    wstrb_d = 4'b0001 << off;
                    wdata_d = {4{valB[7:0]}};
                end
                2'b01: begin
                    wstrb_d = 4'b0011 << {off[1], 1'b0};
                    wdata_d = {2{valB[15:0]}};
                end
                2'b10: begin
                    wstrb_d = 4'b1111;
                    wdata_d = valB;
                end
                default: begin
                    wstrb_d = '0;
                    wdata_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        byte_v = 8'h00;
        unique case (addr_q[1:0])
            2'd0: byte_v = mem.mem_rdata[7:0];
            2'd1: byte_v = mem.mem_rdata[15:8];
            2'd2: byte_v = mem.mem_rdata[23:16];
            2'd3: byte_v = mem.mem_rdata[31:24];
        endcase
    end

    assign half_v = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        load_fmt = '0;
        unique case (f3_q)
            3'b000:  load_fmt = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_fmt = {24'h0, byte_v};
            3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
            3'b101:  load_fmt = {16'h0, half_v};
            3'b010:  load_fmt = mem.mem_rdata;
            default: load_fmt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
        end else if (capture) begin
            addr_q  <= valE;
            f3_q    <= func3;
            we_q    <= is_store;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            valm_q  <= '0;
        end else if (rsp_take & ~we_q) begin
            valm_q  <= load_fmt;
        end
    end

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (capture) begin
            mis_q <= mis_trap;
        end
    end

    assign misaligned = (state_q == DONE) & mis_q;
`endif

    always_comb begin
        state_d           = state_q;
        done              = 1'b0;
        valM              = '0;
        mem.mem_req_valid = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_we        = 1'b0;
        mem.mem_wstrb     = '0;
        mem.mem_wdata     = '0;
        // Inputs stay frozen through the whole access, released in DONE.
        stall = in_valid & is_mem & (state_q != DONE);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem) begin
                        state_d = skip ? DONE : REQ;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_addr      = {addr_q[XLEN-1:2], 2'b00};
                mem.mem_we        = we_q;
                mem.mem_wstrb     = wstrb_q;
                mem.mem_wdata     = wdata_q;
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                valM    = valm_q;
                state_d = IDLE;
            end
        endcase
        // Combinational outputs read as reset values while rst is held.
        if (rst) begin
            done  = 1'b0;
            stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset and
// stray-response sequences, then random traffic against a byte-array model.
module tb_memory_stage;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] valE, valB, valM;
    logic        done, stall, misaligned;

    always #5 clk = ~clk;

    memory_stage_if #(.XLEN(32)) mif ();

    memory_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .opcode     (opcode),
        .func3      (func3),
        .valE       (valE),
        .valB       (valB),
        .valM       (valM),
        .done       (done),
        .stall      (stall),
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        .misaligned (misaligned),
`endif
        .mem        (mif)
    );

`ifndef MEMORY_STAGE_MISALIGN_TRAP_EN
    assign misaligned = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Memory side: word array plus request log.
    logic [31:0] mem_words [256];
    int          rdy_dly = 0;
    int          rsp_dly = 0;
    int          req_count = 0;
    logic [31:0] last_addr = '0;
    logic        last_we = 1'b0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] last_wdata = '0;
    bit          stray = 1'b0;
    bit          pending = 1'b0;
    int          rc = 0;
    int          sc = 0;
    logic [31:0] rd = '0;

    // Reference model: plain byte array.
    int ref_mem [1024];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    initial begin
        mif.mem_req_ready = 1'b0;
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rdata     = '0;
        forever begin
            @(negedge clk);
            mif.mem_rsp_valid = 1'b0;
            if (stray) begin
                mif.mem_rsp_valid = 1'b1;
                mif.mem_rdata     = 32'hDEAD_BEEF;
                stray             = 1'b0;
            end else if (pending) begin
                if (sc >= rsp_dly) begin
                    mif.mem_rsp_valid = 1'b1;
                    mif.mem_rdata     = rd;
                    pending           = 1'b0;
                end else begin
                    sc++;
                end
            end
            if (mif.mem_req_valid && !mif.mem_req_ready) begin
                if (rc >= rdy_dly) begin
                    mif.mem_req_ready = 1'b1;
                    req_count++;
                    last_addr  = mif.mem_addr;
                    last_we    = mif.mem_we;
                    last_wstrb = mif.mem_wstrb;
                    last_wdata = mif.mem_wdata;
                    if (mif.mem_we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (mif.mem_wstrb[k])
                                mem_words[mif.mem_addr[9:2]][8*k +: 8] =
                                    mif.mem_wdata[8*k +: 8];
                        end
                        rd = '0;
                    end else begin
                        rd = mem_words[mif.mem_addr[9:2]];
                    end
                    pending = 1'b1;
                    sc      = 0;
                end else begin
                    rc++;
                end
            end else begin
                mif.mem_req_ready = 1'b0;
                rc = 0;
            end
        end
    end

    // Present one instruction and wait (bounded) for done.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] vm, output int lat,
                          output logic st0, output logic std,
                          output logic mis);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        func3    = f3;
        valE     = a;
        valB     = d;
        lat      = 0;
        #1;
        st0 = stall;
        while (!done && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles, want done", lat);
        end
        vm  = valM;
        std = stall;
        mis = misaligned;
    endtask

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          rdy;
        int          rsp;
        logic [31:0] exp_vm;
        int          exp_lat;
        int          exp_reqs;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string nm, input logic [6:0] op, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdt,
        input int rdy, input int rsp, input logic [31:0] evm, input int elat,
        input int ereq, input logic [31:0] eaddr, input logic ewe,
        input logic [3:0] estrb, input logic [31:0] ewd, input logic emis);
        vec_t v;
        v.name = nm;      v.op = op;        v.f3 = f3;
        v.addr = a;       v.wd = wd;        v.rdata = rdt;
        v.rdy = rdy;      v.rsp = rsp;      v.exp_vm = evm;
        v.exp_lat = elat; v.exp_reqs = ereq; v.exp_addr = eaddr;
        v.exp_we = ewe;   v.exp_wstrb = estrb; v.exp_wdata = ewd;
        v.exp_mis = emis;
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        longint v;
        int     b;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            v = ref_mem[a];
            if (f3 == 3'b000 && v >= 128) v -= 256;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            b = a - (a % 2);
            v = ref_mem[b] + 256 * ref_mem[b+1];
            if (f3 == 3'b001 && v >= 32768) v -= 65536;
        end else begin
            b = a - (a % 4);
            v = ref_mem[b] + 256 * (ref_mem[b+1] + 256 * (ref_mem[b+2]
                + 256 * longint'(ref_mem[b+3])));
        end
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a,
                             input logic [31:0] d);
        int n;
        int b;
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        b = a - (a % n);
        for (int k = 0; k < n; k++)
            ref_mem[b+k] = int'((d >> (8*k)) & 32'hFF);
    endtask

    logic [31:0] vm;
    int          lat;
    logic        st0, std, mis;
    int          r0;
    int          seen_done;
    int          bad_words;

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = '0; func3 = '0;
        valE = '0; valB = '0;
        for (int i = 0; i < 256; i++) mem_words[i] = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_valM", valM, 32'd0);
        chk("rst_req_valid", {31'b0, mif.mem_req_valid}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_we", {31'b0, mif.mem_we}, 32'd0);
        chk("rst_wstrb", {28'b0, mif.mem_wstrb}, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_mis", {31'b0, misaligned}, 32'd0);
        rst = 1'b0;

        vecs.push_back(mk("add", ADD, 3'b000, 32'h1234, 32'h5, 32'h0, 0, 0,
                          32'h0, 0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0));
        vecs.push_back(mk("lb", LOAD, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF12,
                          0, 0, 32'hFFFF_FF80, 3, 1, 32'h1000, 1'b0, 4'h0,
                          32'h0, 1'b0));
        vecs.push_back(mk("lbu", LOAD, 3'b100, 32'h1002, 32'h0, 32'h80FF_FF12,
                          0, 0, 32'h0000_00FF, 3, 1, 32'h1000, 1'b0, 4'h0,
                          32'h0, 1'b0));
        vecs.push_back(mk("lhu", LOAD, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234,
                          2, 0, 32'h0000_BEEF, 5, 1, 32'h2000, 1'b0, 4'h0,
                          32'h0, 1'b0));
        vecs.push_back(mk("lh", LOAD, 3'b001, 32'h0010, 32'h0, 32'h1234_8001,
                          0, 2, 32'hFFFF_8001, 5, 1, 32'h0010, 1'b0, 4'h0,
                          32'h0, 1'b0));
        vecs.push_back(mk("sb", STORE, 3'b000, 32'h3001, 32'h0000_00A5, 32'h0,
                          0, 0, 32'h0, 3, 1, 32'h3000, 1'b1, 4'b0010,
                          32'hA5A5_A5A5, 1'b0));
        vecs.push_back(mk("sh", STORE, 3'b001, 32'h0022, 32'h1234_BEEF, 32'h0,
                          0, 0, 32'h0, 3, 1, 32'h0020, 1'b1, 4'b1100,
                          32'hBEEF_BEEF, 1'b0));
        vecs.push_back(mk("sw", STORE, 3'b010, 32'h0030, 32'h0102_0304, 32'h0,
                          1, 1, 32'h0, 5, 1, 32'h0030, 1'b1, 4'b1111,
                          32'h0102_0304, 1'b0));
        vecs.push_back(mk("ld_ill", LOAD, 3'b011, 32'h0040, 32'h0, 32'h1111,
                          0, 0, 32'h0, 1, 0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0));
        vecs.push_back(mk("st_ill", STORE, 3'b100, 32'h0044, 32'hFF, 32'h0,
                          0, 0, 32'h0, 1, 0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0));
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis", LOAD, 3'b010, 32'h4002, 32'h0,
                          32'hCAFE_F00D, 0, 0, 32'h0, 1, 0, 32'h0, 1'b0,
                          4'h0, 32'h0, 1'b1));
        vecs.push_back(mk("sh_mis", STORE, 3'b001, 32'h0041, 32'h0000_ABCD,
                          32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 1'b0, 4'h0,
                          32'h0, 1'b1));
`else
        vecs.push_back(mk("lw_mis", LOAD, 3'b010, 32'h4002, 32'h0,
                          32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 3, 1,
                          32'h4000, 1'b0, 4'h0, 32'h0, 1'b0));
        vecs.push_back(mk("sh_mis", STORE, 3'b001, 32'h0041, 32'h0000_ABCD,
                          32'h0, 0, 0, 32'h0, 3, 1, 32'h0040, 1'b1, 4'b0011,
                          32'hABCD_ABCD, 1'b0));
`endif

        foreach (vecs[i]) begin
            rdy_dly = vecs[i].rdy;
            rsp_dly = vecs[i].rsp;
            mem_words[vecs[i].addr[9:2]] = vecs[i].rdata;
            r0 = req_count;
            run_op(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   vm, lat, st0, std, mis);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_valM"}, vm, vecs[i].exp_vm);
            chk({vecs[i].name, "_stall0"}, {31'b0, st0},
                {31'b0, (vecs[i].op == LOAD || vecs[i].op == STORE)});
            chk({vecs[i].name, "_stall_done"}, {31'b0, std}, 32'd0);
            chk({vecs[i].name, "_reqs"}, req_count - r0, vecs[i].exp_reqs);
            chk({vecs[i].name, "_mis"}, {31'b0, mis}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].exp_reqs > 0) begin
                chk({vecs[i].name, "_addr"}, last_addr, vecs[i].exp_addr);
                chk({vecs[i].name, "_we"}, {31'b0, last_we},
                    {31'b0, vecs[i].exp_we});
                chk({vecs[i].name, "_wstrb"}, {28'b0, last_wstrb},
                    {28'b0, vecs[i].exp_wstrb});
                if (vecs[i].exp_we)
                    chk({vecs[i].name, "_wdata"}, last_wdata,
                        vecs[i].exp_wdata);
            end
        end

        // Back-to-back non-memory ops complete every cycle.
        run_op(ADDI, 3'b000, 32'h0, 32'h0, vm, lat, st0, std, mis);
        chk("b2b_0_lat", lat, 0);
        run_op(ADD, 3'b000, 32'h0, 32'h0, vm, lat, st0, std, mis);
        chk("b2b_1_lat", lat, 0);

        // Reset in WAIT, then a late response must be ignored.
        rdy_dly = 0;
        rsp_dly = 4;
        mem_words[20] = 32'h7777_7777;
        @(negedge clk);
        in_valid = 1'b1; opcode = LOAD; func3 = 3'b010;
        valE = 32'h50; valB = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_done", {31'b0, done}, 32'd0);
        chk("rstw_stall", {31'b0, stall}, 32'd0);
        chk("rstw_valM", valM, 32'd0);
        chk("rstw_req_valid", {31'b0, mif.mem_req_valid}, 32'd0);
        chk("rstw_addr", mif.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (done || mif.mem_req_valid) seen_done++;
        end
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done || mif.mem_req_valid) seen_done++;
        end
        chk("stray_rsp_ignored", seen_done, 0);
        rsp_dly = 0;
        run_op(LOAD, 3'b010, 32'h50, 32'h0, vm, lat, st0, std, mis);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_valM", vm, 32'h7777_7777);

        // Random traffic against the byte-array model.
        for (int i = 0; i < 256; i++) begin
            mem_words[i] = $urandom;
            for (int k = 0; k < 4; k++)
                ref_mem[4*i+k] = int'((mem_words[i] >> (8*k)) & 32'hFF);
        end
        for (int n = 0; n < 300; n++) begin
            int          kind, a, elat;
            logic [2:0]  f3;
            logic [6:0]  op;
            logic [31:0] addr, d, evm;
            logic        ill, emis;
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, 1023);
            addr = ($urandom & 32'hFFFF_FC00) | a;
            d    = $urandom;
            rdy_dly = $urandom_range(0, 2);
            rsp_dly = $urandom_range(0, 2);
            if (kind < 2) begin
                op = kind[0] ? ADD : ADDI;
                f3 = 3'($urandom_range(0, 7));
            end else if (kind < 6) begin
                op = LOAD;
                f3 = ($urandom_range(0, 9) == 0) ? 3'b110 :
                     3'($urandom_range(0, 2));
                if (f3 != 3'b110 && f3 != 3'b010 && $urandom_range(0, 1) == 1)
                    f3 = f3 | 3'b100;
            end else begin
                op = STORE;
                f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) :
                     3'($urandom_range(0, 2));
            end
            ill = (op == LOAD && (f3 == 3'b011 || f3 >= 3'b110))
               || (op == STORE && f3 >= 3'b011);
            emis = 1'b0;
`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
            if (!ill && (op == LOAD || op == STORE))
                emis = ((f3[1:0] == 2'b01) && (a % 2 != 0))
                    || ((f3[1:0] == 2'b10) && (a % 4 != 0));
`endif
            evm = '0;
            if (op != LOAD && op != STORE) begin
                elat = 0;
            end else if (ill || emis) begin
                elat = 1;
            end else begin
                elat = 3 + rdy_dly + rsp_dly;
                if (op == LOAD) evm = ref_load(f3, a);
                else ref_store(f3, a, d);
            end
            run_op(op, f3, addr, d, vm, lat, st0, std, mis);
            chk($sformatf("rnd%0d_lat", n), lat, elat);
            chk($sformatf("rnd%0d_valM", n), vm, evm);
            chk($sformatf("rnd%0d_mis", n), {31'b0, mis}, {31'b0, emis});
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        bad_words = 0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++)
                if (int'((mem_words[i] >> (8*k)) & 32'hFF) != ref_mem[4*i+k])
                    bad_words++;
        end
        chk("mem_image_bad_bytes", bad_words, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of the execute stage. Consumes the computed address (`valE`) and store data (`valB`) for LOAD/STORE instructions and runs a multi-cycle request/response transaction with the data memory. Formats load data (byte/halfword extraction, sign/zero extension) into `valM`. Holds the pipeline with `stall` until the access completes; non-memory instructions pass through in one cycle.

## Interface
Parameters:
- `XLEN`, 32, data/address width. Only 32 is supported; `XLEN/8` byte lanes.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a valid instruction is presented this cycle.
- `opcode`  in  7  instruction opcode, from the `opcodes` package: LOAD = 7'b0000011, STORE = 7'b0100011.
- `func3`  in  3  width/sign select.
- `valE`  in  XLEN  effective byte address from execute.
- `valB`  in  XLEN  store data (rs2).
- `valM`  out  XLEN  formatted load data; valid while `done`=1.
- `done`  out  1  instruction complete this cycle.
- `stall`  out  1  upstream must hold all inputs stable.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`  out  XLEN  word-aligned address: `{addr[XLEN-1:2], 2'b00}`.
- `mem_we`  out  1  1 = store.
- `mem_wstrb`  out  XLEN/8  byte-write enables; 0 for loads.
- `mem_wdata`  out  XLEN  lane-aligned store data.
- `mem_rsp_valid`  in  1  response (read data, or write acknowledge) valid for one cycle.
- `mem_rdata`  in  XLEN  read word.
- `misaligned`  out  1  present only with `MEMORY_STAGE_MISALIGN_TRAP_EN`.

## Operation
State machine:
- `IDLE`:
  - `in_valid` with a non-memory opcode: `done`=1, `stall`=0, `valM`=0 (combinational, same cycle).
  - `in_valid` with LOAD or STORE: capture opcode, func3, address and store data; go to `REQ`.
  - Illegal func3 (load 011/110/111, store 011–111): capture and go directly to `DONE` with no memory request; `valM`=0.
- `REQ`: `mem_req_valid`=1; address, write enable, strobes and data come from captured registers. When `mem_req_ready`=1, go to `WAIT`. Hold `REQ` while ready is low.
- `WAIT`: on `mem_rsp_valid`=1, register the formatted load data (loads) and go to `DONE`.
- `DONE`: `done`=1 for exactly one cycle; `valM` is driven from its register. Next state is `IDLE`.

Rules:
- `stall` = `in_valid` AND memory opcode AND state ≠ `DONE`. It is also 1 during the capture cycle in `IDLE`.
- Load formatting uses `off` = `addr[1:0]`:
  - LB (000) / LBU (100): byte `off`, sign-/zero-extended.
  - LH (001) / LHU (101): halfword `off[1]`, sign-/zero-extended.
  - LW (010): full word.
- Store strobes and data:
  - SB: `wstrb` = `4'b0001 << off`; `wdata` = byte replicated ×4.
  - SH: `wstrb` = `4'b0011 << {off[1],1'b0}`; `wdata` = halfword replicated ×2.
  - SW: `wstrb` = `4'b1111`; `wdata` = `valB`.
- `mem_rsp_valid` outside `WAIT` is ignored.

## Timing
- Reset values: state=`IDLE`, `valM`=0, `done`=0, `stall`=0, `mem_req_valid`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `misaligned`=0.
- Capture at cycle 0, request at cycle 1. With ready=1 at cycle 1 and response at cycle 2, `done` is asserted at cycle 3. Minimum memory-op latency is 3 cycles; each ready or response wait cycle adds one.
- Non-memory ops: 0-cycle latency, back-to-back every cycle.
- A new instruction may be presented in the cycle after `DONE`.
- Reset asserted mid-transaction: immediate return to `IDLE` and the transaction is abandoned. The data memory must share `rst`.

## Configuration
- `MEMORY_STAGE_MISALIGN_TRAP_EN` defined:
  - Misaligned access is detected in `IDLE`: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Such an access skips the memory and goes to `DONE` with `misaligned`=1, `valM`=0.
- Undefined:
  - No `misaligned` port.
  - Misaligned accesses are issued with the offset truncated to natural alignment: halfword uses `off[1]`, word ignores `off`.

## Test plan
- ADD passes through: opcode 0110011, `in_valid`=1 → `done`=1 and `stall`=0 in the same cycle, no memory request.
- LB at `valE`=0x1003, `mem_rdata`=0x80FF_FF12, ready and response immediate → `mem_addr`=0x1000, `done` at cycle 3, `valM`=0xFFFF_FF80.
- LHU at 0x2002, rdata 0xBEEF_1234, ready low for 2 cycles → `done` at cycle 5, `valM`=0x0000_BEEF.
- SB `valB`=0x0000_00A5 at 0x3001 → `wstrb`=0010, `wdata`=0xA5A5_A5A5, `mem_we`=1.
- LW at 0x4002 → with the macro: `misaligned`=1, no request, `done` at cycle 1. Without the macro: `mem_addr`=0x4000, full word returned.
- `rst` pulsed while in `WAIT` → all outputs at reset values; a later `mem_rsp_valid` is ignored.
